di_fifo_terminal: RTL and testbench

Host-interface terminal that sits directly downstream of the I2C host interface on the `di_*` bus and bridges host word transfers to two local streaming FIFOs. Host writes to the data window push into a TX FIFO drained by local logic; host reads from the data window pop an RX FIFO filled by local logic. A status register and a control register share the same terminal address. Flow control is exposed through `di_write_rdy`/`di_read_rdy` and errors through `di_transfer_status`.

---
 rtl/di_fifo_terminal.sv | 198 +++++++++++++++++++
 tb/tb_di_fifo_terminal.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/di_fifo_terminal.sv
// Host-side terminal on the di_* bus: host writes to the data window feed a TX FIFO,
// host reads from it drain an RX FIFO, with a shared STATUS/CONTROL register pair.
module di_fifo_terminal #(
  parameter logic [15:0] TERM_ADDR      = 16'h0050,
  parameter int          DEPTH          = 16,
  parameter int          AW             = 4,
  parameter int          NUM_DATA_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] di_term_addr,
  input  logic [31:0] di_reg_addr,
  input  logic        di_read_mode,
  input  logic        di_write_mode,
  input  logic        di_read,
  input  logic        di_write,
  input  logic [31:0] di_reg_datai,
  output logic        di_read_rdy,
  output logic [31:0] di_reg_datao,
  output logic        di_write_rdy,
  output logic [15:0] di_transfer_status,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [1:0]    BEAT_LAST = 2'(NUM_DATA_BYTES - 1);

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];

  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ovf_q, ovf_d, bad_q, bad_d, err_q, err_d;
  logic [1:0]    rd_beat_q, rd_beat_d;

  logic          sel, dwin, is_status, is_ctrl;
  logic          wr_stb, rd_stb;
  logic          tx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          flush, clr_sticky, ovf_evt, wr_bad, rd_bad, pop_try;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^di_reg_addr[31:8];

  // Address decode and access qualification
  assign sel       = (di_term_addr == TERM_ADDR);
  assign dwin      = ~di_reg_addr[7];
  assign is_status = (di_reg_addr[7:0] == 8'h80);
  assign is_ctrl   = (di_reg_addr[7:0] == 8'h81);

  assign wr_stb = sel & di_write;
  assign rd_stb = sel & di_read_mode & di_read;

  assign tx_full  = (tx_cnt_q == CNT_FULL);
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_push    = wr_stb & dwin & ~tx_full;
  assign ovf_evt    = wr_stb & dwin & tx_full;
  assign flush      = wr_stb & is_ctrl & di_reg_datai[0];
  assign clr_sticky = wr_stb & is_ctrl & di_reg_datai[1];
  assign wr_bad     = wr_stb & ~dwin & ~is_ctrl;

  // Only the first beat of each host word pops the RX FIFO
  assign pop_try = rd_stb & (rd_beat_q == 2'd0) & dwin;
  assign rx_pop  = pop_try & ~rx_empty;
  assign rd_bad  = (pop_try & rx_empty) | (rd_stb & ~dwin & ~is_status);

  assign tx_valid = (tx_cnt_q != '0);
  assign tx_data  = tx_mem[tx_rptr_q];
  assign tx_pop   = tx_valid & tx_ready;

  assign rx_ready = (rx_cnt_q != CNT_FULL);
  assign rx_push  = rx_valid & rx_ready;

  assign status_word = {ovf_q, bad_q, 14'b0, 8'(tx_cnt_q), 8'(rx_cnt_q)};

  // Host-facing outputs are combinational from registers and bus inputs
  assign di_read_rdy  = ~sel | ~di_read_mode | ~dwin | ~rx_empty;
  assign di_write_rdy = ~sel | ~dwin | ~tx_full;
  assign di_transfer_status = sel ? {15'b0, err_q} : 16'h0000;

  always_comb begin
    di_reg_datao = 32'h0;
    if (sel && di_read_mode) begin
      if (dwin) begin
        di_reg_datao = rx_empty ? 32'h0 : rx_mem[rx_rptr_q];
      end else if (is_status) begin
        di_reg_datao = status_word;
      end
    end
  end

  // FIFO pointer and count next-state; flush overrides every push and pop
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CNT_ONE;
        2'b01:   tx_cnt_d = tx_cnt_q - CNT_ONE;
        default: tx_cnt_d = tx_cnt_q;
      endcase
      if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CNT_ONE;
        2'b01:   rx_cnt_d = rx_cnt_q - CNT_ONE;
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  // Stickies: a new event wins over a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    bad_d = bad_q;
    err_d = err_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (clr_sticky) begin
      ovf_d = 1'b0;
    end
    if (wr_bad || rd_bad) begin
      bad_d = 1'b1;
    end else if (clr_sticky) begin
      bad_d = 1'b0;
    end
    if (ovf_evt || wr_bad || rd_bad) begin
      err_d = 1'b1;
    end else if (sel && !di_read_mode && !di_write_mode) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    rd_beat_d = rd_beat_q;
    if (sel && !di_read_mode) begin
      rd_beat_d = 2'd0;
    end else if (rd_stb) begin
      rd_beat_d = (rd_beat_q == BEAT_LAST) ? 2'd0 : rd_beat_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_beat_q <= 2'd0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      rd_beat_q <= rd_beat_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counts
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= di_reg_datai;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_di_fifo_terminal.sv
// Directed bench for di_fifo_terminal: host bursts, FIFO flow control, error flags,
// flush and asynchronous reset, each against hand-computed values.
module tb_di_fifo_terminal;

  localparam logic [15:0] TA = 16'h0050;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_read_mode, di_write_mode, di_read, di_write;
  logic [31:0] di_reg_datai;
  logic        di_read_rdy, di_write_rdy;
  logic [31:0] di_reg_datao;
  logic [15:0] di_transfer_status;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid, rx_ready;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  di_fifo_terminal #(
    .TERM_ADDR(TA), .DEPTH(16), .AW(4), .NUM_DATA_BYTES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_read_mode(di_read_mode), .di_write_mode(di_write_mode),
    .di_read(di_read), .di_write(di_write), .di_reg_datai(di_reg_datai),
    .di_read_rdy(di_read_rdy), .di_reg_datao(di_reg_datao),
    .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [31:0] addr, input logic [31:0] data);
    di_write_mode = 1'b1;
    di_reg_addr   = addr;
    di_reg_datai  = data;
    di_write      = 1'b1;
    tick();
    di_write      = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [31:0] exp);
    di_read_mode = 1'b1;
    di_reg_addr  = 32'h80;
    #1;
    chk(tag, di_reg_datao, exp);
  endtask

  task automatic end_txn();
    di_read_mode  = 1'b0;
    di_write_mode = 1'b0;
    di_read       = 1'b0;
    di_write      = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [3];
    logic [31:0] exp_d;
    w[0] = 32'hA1A1A1A1; w[1] = 32'hA2A2A2A2; w[2] = 32'hA3A3A3A3;

    reset_n = 1'b0; di_term_addr = TA; di_reg_addr = '0; di_reg_datai = '0;
    di_read_mode = 1'b0; di_write_mode = 1'b0; di_read = 1'b0; di_write = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #2;
    chk("rst read_rdy", 32'(di_read_rdy), 32'd1);
    chk("rst write_rdy", 32'(di_write_rdy), 32'd1);
    chk("rst datao", di_reg_datao, 32'h0);
    chk("rst xfer_status", 32'(di_transfer_status), 32'h0);
    chk("rst tx_valid", 32'(tx_valid), 32'd0);
    chk("rst rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk); #1 reset_n = 1'b1;
    tick();

    // Host writes drain through TX
    host_wr(32'h00, 32'hDEADBEEF);
    chk("t1 tx_valid", 32'(tx_valid), 32'd1);
    chk("t1 tx_data0", tx_data, 32'hDEADBEEF);
    host_wr(32'h01, 32'h12345678);
    tx_ready = 1'b1;
    tick();
    chk("t1 tx_data1", tx_data, 32'h12345678);
    chk("t1 tx_valid1", 32'(tx_valid), 32'd1);
    tick();
    chk("t1 tx drained", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    chk_status("t1 status", 32'h0);
    end_txn();

    // RX fill, then a 12-beat read burst
    di_read_mode = 1'b1; di_reg_addr = 32'h0;
    #1 chk("t2 rdy empty", 32'(di_read_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rx_data = w[i]; rx_valid = 1'b1;
      tick();
      if (i == 0) chk("t2 rdy latency", 32'(di_read_rdy), 32'd1);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      di_reg_addr = 32'(i);
      di_read = 1'b1;
      #1;
      if (i % 4 == 0) begin
        chk($sformatf("t2 beat%0d", i), di_reg_datao, w[i/4]);
      end else if (i % 4 == 3) begin
        exp_d = (i / 4 < 2) ? w[i/4 + 1] : 32'h0;
        chk($sformatf("t2 beat%0d", i), di_reg_datao, exp_d);
      end
      tick();
    end
    di_read = 1'b0;
    chk("t2 no err", 32'(di_transfer_status), 32'h0);
    chk_status("t2 status", 32'h0);
    end_txn();

    // TX overflow
    for (int i = 0; i < 16; i++) host_wr(32'(i), 32'h100 + 32'(i));
    di_reg_addr = 32'h0;
    #1;
    chk("t3 wrdy full", 32'(di_write_rdy), 32'd0);
    chk("t3 tx head", tx_data, 32'h100);
    chk("t3 no err yet", 32'(di_transfer_status), 32'h0);
    host_wr(32'h00, 32'hBAD0BAD0);
    chk("t3 ovf err", 32'(di_transfer_status), 32'h1);
    chk_status("t3 status", 32'h80001000);
    end_txn();
    chk("t3 err clr", 32'(di_transfer_status), 32'h0);
    host_wr(32'h81, 32'h3);
    chk("t3 flush tx_valid", 32'(tx_valid), 32'd0);
    chk_status("t3 after ctrl", 32'h0);
    end_txn();

    // Other terminal selected
    di_term_addr = 16'h0051;
    di_write_mode = 1'b1; di_reg_addr = 32'h0; di_reg_datai = 32'h5555; di_write = 1'b1;
    #1;
    chk("t4 wrdy", 32'(di_write_rdy), 32'd1);
    chk("t4 xfer", 32'(di_transfer_status), 32'h0);
    tick();
    di_reg_addr = 32'h80;
    tick();
    di_write = 1'b0; di_read_mode = 1'b1; di_reg_addr = 32'h0;
    #1;
    chk("t4 rrdy", 32'(di_read_rdy), 32'd1);
    chk("t4 datao", di_reg_datao, 32'h0);
    chk("t4 tx_valid", 32'(tx_valid), 32'd0);
    di_term_addr = TA;
    chk_status("t4 status", 32'h0);
    end_txn();

    // Bad accesses and sticky clear
    host_wr(32'h80, 32'h1);
    chk("t5 wr status err", 32'(di_transfer_status), 32'h1);
    chk_status("t5 bad sticky", 32'h40000000);
    end_txn();
    chk("t5 err clr", 32'(di_transfer_status), 32'h0);
    host_wr(32'h90, 32'h2);
    chk("t5 wr illegal err", 32'(di_transfer_status), 32'h1);
    end_txn();
    di_read_mode = 1'b1; di_reg_addr = 32'h81; di_read = 1'b1;
    tick();
    di_read = 1'b0;
    chk("t5 rd ctrl err", 32'(di_transfer_status), 32'h1);
    end_txn();
    di_read_mode = 1'b1; di_reg_addr = 32'h0; di_read = 1'b1;
    tick();
    di_read = 1'b0;
    chk("t5 pop empty err", 32'(di_transfer_status), 32'h1);
    end_txn();
    host_wr(32'h00, 32'h0000CAFE);
    host_wr(32'h81, 32'h2);
    chk("t5 ctrl no err", 32'(di_transfer_status), 32'h0);
    chk_status("t5 sticky clr", 32'h00000100);
    end_txn();

    // Beat counter clears between transactions, then flush
    for (int i = 0; i < 7; i++) begin
      rx_data = 32'h600 + 32'(i); rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    di_read_mode = 1'b1; di_reg_addr = 32'h0; di_read = 1'b1;
    #1 chk("t6 pop0", di_reg_datao, 32'h600);
    tick();
    di_read = 1'b0;
    end_txn();
    di_read_mode = 1'b1; di_reg_addr = 32'h0; di_read = 1'b1;
    #1 chk("t6 beat cleared", di_reg_datao, 32'h601);
    tick();
    di_read = 1'b0;
    end_txn();
    host_wr(32'h00, 32'h0000F00D);
    chk_status("t6 pre flush", 32'h00000205);
    di_read_mode = 1'b0;
    di_reg_addr = 32'h81; di_reg_datai = 32'h1; di_write = 1'b1;
    rx_data = 32'h777; rx_valid = 1'b1;
    tick();
    di_write = 1'b0; rx_valid = 1'b0;
    chk("t6 tx_valid", 32'(tx_valid), 32'd0);
    chk("t6 rx_ready", 32'(rx_ready), 32'd1);
    chk_status("t6 flushed", 32'h0);
    end_txn();

    // Asynchronous reset in the middle of a read burst
    for (int i = 0; i < 2; i++) begin
      rx_data = 32'h800 + 32'(i); rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    host_wr(32'h00, 32'h900);
    host_wr(32'h00, 32'h901);
    host_wr(32'h80, 32'h0);
    di_read_mode = 1'b1; di_reg_addr = 32'h0; di_read = 1'b1;
    tick();
    di_reg_addr = 32'h80;
    #1;
    chk("t7 pre status", di_reg_datao, 32'h40000201);
    chk("t7 pre err", 32'(di_transfer_status), 32'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("t7 rst tx_valid", 32'(tx_valid), 32'd0);
    chk("t7 rst rx_ready", 32'(rx_ready), 32'd1);
    chk("t7 rst datao", di_reg_datao, 32'h0);
    chk("t7 rst xfer", 32'(di_transfer_status), 32'h0);
    chk("t7 rst wrdy", 32'(di_write_rdy), 32'd1);
    chk("t7 rst rrdy", 32'(di_read_rdy), 32'd1);
    di_read = 1'b0; di_read_mode = 1'b0; di_write_mode = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    tick();
    chk_status("t7 post status", 32'h0);
    end_txn();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
